ram_clearable: RTL and testbench

- Parametrised successor to the fixed 8-word, 16-bit Hack RAM: WIDTH-bit words, DEPTH entries.
- Keeps Hack semantics: combinational read of the addressed word; write on the rising clock edge when load is high.
- Adds a hardware clear engine. After reset, or on a clear request, it sweeps every entry to zero, one word per cycle, and reports readiness.
- Sits in the chapter-03 memory hierarchy as the building block for larger RAMs that need deterministic power-up contents.

---
 rtl/ram_clearable_pkg.sv | 10 +
 rtl/ram_clearable_clear_sequencer.sv | 38 +++
 rtl/ram_clearable.sv | 39 +++
 tb/tb_ram_clearable.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ram_clearable_pkg.sv
// ram_clearable_pkg: shared state encodings and address-width helper for the clearable RAM
package ram_clearable_pkg;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  function automatic int clog2(input int n);
    int r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/ram_clearable_clear_sequencer.sv
// ram_clearable_clear_sequencer: owns state, sweep pointer and ready; walks every word to zero
module ram_clearable_clear_sequencer
  import ram_clearable_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  output logic              ready,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (!reset_n) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
    end else if (state_q == ST_CLEAR) begin
      state_d = ptr_q == ADDR_W'(DEPTH - 1) ? ST_READY : ST_CLEAR;
      ptr_d   = ptr_q == ADDR_W'(DEPTH - 1) ? ptr_q : ptr_q + ADDR_W'(1);
    end else if (clear) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
    end
  end
  always_ff @(posedge clock) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
  end
  assign ready      = state_q == ST_READY;
  assign sweep_we   = state_q == ST_CLEAR && reset_n;
  assign sweep_addr = ptr_q;
endmodule

// File: rtl/ram_clearable.sv
// ram_clearable: Hack-style RAM (combinational read, clocked write) with a zeroing sweep after reset/clear
module ram_clearable
  import ram_clearable_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              ready
);
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              sweep_we, in_range, user_we;
  logic [ADDR_W-1:0] sweep_addr, wr_addr;
  logic [WIDTH-1:0]  wr_data;
  ram_clearable_clear_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .ready      (ready),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );
  // clear beats a same-edge load; out stays 0 until the sweep has finished
  always_comb begin
    in_range = {1'b0, address} < (ADDR_W + 1)'(DEPTH);
    user_we  = ready && reset_n && load && !clear && in_range;
    wr_addr  = sweep_we ? sweep_addr : address;
    wr_data  = sweep_we ? '0 : in;
    out      = ready && in_range ? mem[address] : '0;
  end
  always_ff @(posedge clock) if (sweep_we || user_we) mem[wr_addr] <= wr_data;
endmodule

// File: tb/tb_ram_clearable.sv
// tb_ram_clearable: directed checks of sweep timing, read/write, clear priority and odd depth
module tb_ram_clearable;
  logic        clock = 0;
  logic        rst_a = 0, load_a = 0, clear_a = 0, ready_a;
  logic [15:0] in_a = 0, out_a;
  logic [2:0]  addr_a = 0;
  logic        rst_b = 0, load_b = 0, clear_b = 0, ready_b;
  logic [15:0] in_b = 0, out_b;
  logic [2:0]  addr_b = 0;
  int checks = 0, failures = 0;

  ram_clearable #(.WIDTH(16), .DEPTH(8)) dut_a (
    .clock(clock), .reset_n(rst_a), .in(in_a), .address(addr_a),
    .load(load_a), .clear(clear_a), .out(out_a), .ready(ready_a));
  ram_clearable #(.WIDTH(16), .DEPTH(5)) dut_b (
    .clock(clock), .reset_n(rst_b), .in(in_b), .address(addr_b),
    .load(load_b), .clear(clear_b), .out(out_b), .ready(ready_b));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sweep(input bit sel_b, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk($sformatf("sweep_rdy_%0d", i), sel_b ? ready_b : ready_a, i == n);
      if (i < n) chk($sformatf("sweep_out_%0d", i), sel_b ? out_b : out_a, 0);
    end
  endtask

  task automatic read_a(input string tag, input int a, input logic [15:0] exp);
    addr_a = 3'(a);
    #1;
    chk($sformatf("%s_a%0d", tag, a), out_a, exp);
  endtask

  task automatic fill_a(input logic [15:0] v);
    load_a = 1;
    in_a = v;
    for (int a = 0; a < 8; a++) begin
      addr_a = 3'(a);
      tick();
    end
    load_a = 0;
  endtask

  initial begin
    // power-up sweep on both instances
    tick();
    tick();
    chk("rst_ready", ready_a, 0);
    chk("rst_out", out_a, 0);
    chk("rst_ready_b", ready_b, 0);
    rst_a = 1;
    sweep(0, 8);
    for (int a = 0; a < 8; a++) read_a("pwr", a, 0);

    // write then immediate read; old word visible before the edge
    addr_a = 5; in_a = 15; load_a = 1;
    #1;
    chk("rdw_old", out_a, 0);
    tick();
    load_a = 0;
    chk("rdw_new", out_a, 15);
    for (int a = 0; a < 8; a++) read_a("wr", a, a == 5 ? 15 : 0);

    // load held through a clear sweep is ignored
    clear_a = 1; addr_a = 3; in_a = 16'hAAAA; load_a = 1;
    tick();
    clear_a = 0;
    chk("clr_ready", ready_a, 0);
    sweep(0, 8);
    load_a = 0;
    read_a("ldsweep", 3, 0);
    read_a("ldsweep", 5, 0);

    // clear wins over a simultaneous load
    fill_a(16'h1234);
    read_a("fill", 7, 16'h1234);
    addr_a = 2; in_a = 16'h5555; load_a = 1; clear_a = 1;
    tick();
    load_a = 0; clear_a = 0;
    chk("clrld_ready", ready_a, 0);
    chk("clrld_out", out_a, 0);
    sweep(0, 8);
    for (int a = 0; a < 8; a++) read_a("clrld", a, 0);

    // reset while ptr=4 restarts the sweep from 0
    fill_a(16'h7777);
    clear_a = 1;
    tick();
    clear_a = 0;
    repeat (4) tick();
    rst_a = 0;
    tick();
    chk("midrst_ready", ready_a, 0);
    chk("midrst_out", out_a, 0);
    rst_a = 1;
    sweep(0, 8);
    for (int a = 0; a < 8; a++) read_a("midrst", a, 0);

    // DEPTH=5: out-of-range write ignored, sweep length 5
    rst_b = 1;
    sweep(1, 5);
    addr_b = 6; in_b = 16'h00FF; load_b = 1;
    tick();
    load_b = 0;
    chk("oor_out", out_b, 0);
    for (int a = 0; a < 5; a++) begin
      addr_b = 3'(a);
      #1;
      chk($sformatf("oor_b%0d", a), out_b, 0);
    end
    addr_b = 4; in_b = 16'h00AB; load_b = 1;
    tick();
    load_b = 0;
    chk("b_wr4", out_b, 16'h00AB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
